// File: rtl/bus_sequencer_if.sv
// Bus sequencer signal bundle: datapath/IR inputs and the timing/decode/bus-select outputs.
// master drives the sequencer inputs; slave is the sequencer itself.
interface bus_sequencer_if #(
  parameter int SC_WIDTH  = 4,
  parameter int SEL_WIDTH = 3
);
  logic                       run;
  logic                       sc_clr;
  logic [2:0]                 ir_op;
  logic                       ir_i;
  logic                       ien;
  logic                       fgi;
  logic                       fgo;
  logic [SC_WIDTH-1:0]        sc;
  logic [(1<<SC_WIDTH)-1:0]   t_state;
  logic [7:0]                 d_dec;
  logic                       i_flag;
  logic                       r_flag;
  logic [SEL_WIDTH-1:0]       bus_sel;

  modport master (
    output run, sc_clr, ir_op, ir_i, ien, fgi, fgo,
    input  sc, t_state, d_dec, i_flag, r_flag, bus_sel
  );

  modport slave (
    input  run, sc_clr, ir_op, ir_i, ien, fgi, fgo,
    output sc, t_state, d_dec, i_flag, r_flag, bus_sel
  );
endinterface

// File: rtl/bus_sequencer.sv
// Timing-and-control core: sequence counter, opcode/indirect latch, interrupt-cycle flop, bus select.
// Optional interrupt cycle is built when BUS_SEQ_INTERRUPT_EN is defined; otherwise R is tied to 0.
//
// state (R, SC)   | meaning
// R=0, T0..T2     | instruction fetch/decode; opcode and I latch at end of T2
// R=0, T3..Tn     | execute using latched D and I
// R=1, any T      | interrupt pending/cycle; latch frozen, R.T2 returns SC to 0 and clears R
module bus_sequencer #(
  parameter int SC_WIDTH  = 4,
  parameter int SEL_WIDTH = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  bus_sequencer_if.slave    bus
);
  localparam int NT = 1 << SC_WIDTH;
  localparam logic [SC_WIDTH-1:0] SC_T2  = SC_WIDTH'(2);
  localparam logic [SC_WIDTH-1:0] SC_ONE = SC_WIDTH'(1);

  logic [SC_WIDTH-1:0] sc_q;
  logic [SC_WIDTH-1:0] sc_d;
  logic [2:0]          op_q;
  logic                i_q;
  logic                r_q;
  logic                r_exit;
  logic                at_t2;
  logic                latch_en;
  logic [NT-1:0]       t;
  logic [7:0]          d;
  logic [7:1]          cond;
  logic [2:0]          sel;

  assign at_t2    = (sc_q == SC_T2);
  assign latch_en = bus.run & ~r_q & at_t2;

  always_comb begin
    t       = '0;
    t[sc_q] = 1'b1;
  end

  always_comb begin
    d       = '0;
    d[op_q] = 1'b1;
  end

`ifdef BUS_SEQ_INTERRUPT_EN
  logic r_set;

  // sc_clr alone is enough to leave the interrupt cycle at T2, even while stopped
  assign r_exit = r_q & at_t2 & (bus.run | bus.sc_clr);
  assign r_set  = bus.run & (sc_q > SC_T2) & bus.ien & (bus.fgi | bus.fgo);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= 1'b0;
    end else if (r_exit) begin
      r_q <= 1'b0;
    end else if (r_set) begin
      r_q <= 1'b1;
    end
  end
`else
  logic unused_irq;

  assign r_q        = 1'b0;
  assign r_exit     = 1'b0;
  assign unused_irq = ^{bus.ien, bus.fgi, bus.fgo};
`endif

  always_comb begin
    sc_d = sc_q;
    if (bus.sc_clr) begin
      sc_d = '0;
    end else if (bus.run) begin
      sc_d = r_exit ? '0 : sc_q + SC_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sc_q <= '0;
      op_q <= 3'd0;
      i_q  <= 1'b0;
    end else begin
      sc_q <= sc_d;
      if (latch_en) begin
        op_q <= bus.ir_op;
        i_q  <= bus.ir_i;
      end
    end
  end

  always_comb begin
    cond[1] = (d[4] & t[4]) | (d[5] & t[5]);
    cond[2] = t[0] | (d[5] & t[4]);
    cond[3] = d[6] & t[6];
    cond[4] = d[3] & t[4];
    cond[5] = ~r_q & t[2];
    cond[6] = r_q & t[1];
    cond[7] = (~r_q & t[1]) | (~d[7] & i_q & t[3]) | ((d[0] | d[1] | d[2]) & t[4]);
  end

  // later (higher) codes overwrite earlier ones, so the highest asserted code wins
  always_comb begin
    sel = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if (cond[k]) sel = 3'(k);
    end
  end

  assign bus.sc      = sc_q;
  assign bus.t_state = t;
  assign bus.d_dec   = d;
  assign bus.i_flag  = i_q;
  assign bus.r_flag  = r_q;
  assign bus.bus_sel = SEL_WIDTH'(sel);
endmodule

// File: tb/tb_bus_sequencer.sv
// Scoreboard bench for bus_sequencer: per-cycle expected state queued with each stimulus step.
// Expectations for the interrupt scenario follow BUS_SEQ_INTERRUPT_EN.
module tb_bus_sequencer;
  localparam int SCW  = 4;
  localparam int SELW = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bus_sequencer_if #(.SC_WIDTH(SCW), .SEL_WIDTH(SELW)) bus ();

  bus_sequencer #(.SC_WIDTH(SCW), .SEL_WIDTH(SELW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    bit       run;
    bit       clr;
    bit [2:0] op;
    bit       ii;
    bit       irq;
    bit [47:0] exp;
  } row_t;

  typedef struct {
    string       tag;
    logic [47:0] v;
  } exp_t;

  exp_t sb[$];
  int   n_pass  = 0;
  int   n_total = 0;

`ifdef BUS_SEQ_INTERRUPT_EN
  localparam bit IRQ_ON = 1'b1;
`else
  localparam bit IRQ_ON = 1'b0;
`endif

  function automatic logic [47:0] expv(int s, int sel, logic [7:0] dv, bit fi, bit r);
    logic [15:0] tv;
    tv = 16'h0001 << s;
    return {tv, 8'(s), 8'(sel), dv, 6'b0, fi, r};
  endfunction

  function automatic logic [47:0] obs();
    return {bus.t_state, 8'(bus.sc), 8'(bus.bus_sel), bus.d_dec, 6'b0, bus.i_flag, bus.r_flag};
  endfunction

  function automatic row_t mk(bit run, bit clr, bit [2:0] op, bit ii, bit irq, logic [47:0] e);
    row_t r;
    r.run = run; r.clr = clr; r.op = op; r.ii = ii; r.irq = irq; r.exp = e;
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply(input row_t r, input string tag);
    bus.run    = r.run;
    bus.sc_clr = r.clr;
    bus.ir_op  = r.op;
    bus.ir_i   = r.ii;
    bus.ien    = r.irq;
    bus.fgi    = r.irq;
    bus.fgo    = 1'b0;
    sb.push_back('{tag, r.exp});
    tick();
  endtask

  task automatic test_reset();
    exp_t        e;
    logic [47:0] got;
    row_t        rows[$];
    rst_n = 1'b0;
    apply(mk(1, 0, 3'd3, 1, 0, expv(0, 2, 8'h01, 0, 0)), "reset_hold");
    tick();
    e = sb.pop_front(); got = obs(); n_total++;
    if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
    else n_pass++;
    rst_n = 1'b1;
    rows.push_back(mk(1, 0, 3'd3, 1, 0, expv(1, 7, 8'h01, 0, 0)));
    rows.push_back(mk(1, 0, 3'd3, 1, 0, expv(2, 5, 8'h01, 0, 0)));
    rows.push_back(mk(1, 0, 3'd3, 1, 0, expv(3, 7, 8'h08, 1, 0)));
    rows.push_back(mk(1, 0, 3'd3, 1, 0, expv(4, 4, 8'h08, 1, 0)));
    foreach (rows[k]) begin
      apply(rows[k], $sformatf("reset_release_%0d", k));
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
      else n_pass++;
    end
    #3;
    sb.push_back('{"reset_mid_t4", expv(0, 2, 8'h01, 0, 0)});
    rst_n = 1'b0;
    #1;
    e = sb.pop_front(); got = obs(); n_total++;
    if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
    else n_pass++;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic test_fetch_indirect();
    exp_t        e;
    logic [47:0] got;
    row_t        rows[$];
    rows.push_back(mk(1, 0, 3'd0, 1, 0, expv(1, 7, 8'h01, 0, 0)));
    rows.push_back(mk(1, 0, 3'd0, 1, 0, expv(2, 5, 8'h01, 0, 0)));
    rows.push_back(mk(1, 0, 3'd0, 1, 0, expv(3, 7, 8'h01, 1, 0)));
    rows.push_back(mk(1, 0, 3'd0, 1, 0, expv(4, 7, 8'h01, 1, 0)));
    rows.push_back(mk(1, 1, 3'd0, 1, 0, expv(0, 2, 8'h01, 1, 0)));
    foreach (rows[k]) begin
      apply(rows[k], $sformatf("fetch_indirect_%0d", k));
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_sta_clear();
    exp_t        e;
    logic [47:0] got;
    row_t        rows[$];
    rows.push_back(mk(1, 0, 3'd3, 0, 0, expv(1, 7, 8'h01, 1, 0)));
    rows.push_back(mk(1, 0, 3'd3, 0, 0, expv(2, 5, 8'h01, 1, 0)));
    rows.push_back(mk(1, 0, 3'd3, 0, 0, expv(3, 0, 8'h08, 0, 0)));
    rows.push_back(mk(1, 0, 3'd3, 0, 0, expv(4, 4, 8'h08, 0, 0)));
    rows.push_back(mk(1, 1, 3'd3, 0, 0, expv(0, 2, 8'h08, 0, 0)));
    foreach (rows[k]) begin
      apply(rows[k], $sformatf("sta_clear_%0d", k));
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_stall_wrap();
    exp_t        e;
    logic [47:0] got;
    row_t        rows[$];
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(1, 7, 8'h08, 0, 0)));
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(2, 5, 8'h08, 0, 0)));
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(3, 0, 8'h20, 0, 0)));
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(4, 2, 8'h20, 0, 0)));
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(5, 1, 8'h20, 0, 0)));
    for (int k = 0; k < 3; k++) rows.push_back(mk(0, 0, 3'd5, 0, 0, expv(5, 1, 8'h20, 0, 0)));
    for (int s = 6; s < 16; s++) rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(s, 0, 8'h20, 0, 0)));
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(0, 2, 8'h20, 0, 0)));
    rows.push_back(mk(1, 0, 3'd5, 0, 0, expv(1, 7, 8'h20, 0, 0)));
    rows.push_back(mk(0, 1, 3'd5, 0, 0, expv(0, 2, 8'h20, 0, 0)));
    foreach (rows[k]) begin
      apply(rows[k], $sformatf("stall_wrap_%0d", k));
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    exp_t        e;
    logic [47:0] got;
    row_t        rows[$];
    rows.push_back(mk(1, 0, 3'd4, 0, 0, expv(1, 7, 8'h20, 0, 0)));
    rows.push_back(mk(1, 0, 3'd4, 0, 0, expv(2, 5, 8'h20, 0, 0)));
    rows.push_back(mk(1, 0, 3'd4, 0, 0, expv(3, 0, 8'h10, 0, 0)));
    rows.push_back(mk(1, 0, 3'd4, 0, 0, expv(4, 1, 8'h10, 0, 0)));
    rows.push_back(mk(1, 1, 3'd7, 1, 0, expv(0, 2, 8'h10, 0, 0)));
    rows.push_back(mk(1, 0, 3'd7, 1, 0, expv(1, 7, 8'h10, 0, 0)));
    rows.push_back(mk(1, 0, 3'd7, 1, 0, expv(2, 5, 8'h10, 0, 0)));
    rows.push_back(mk(1, 0, 3'd7, 1, 0, expv(3, 0, 8'h80, 1, 0)));
    rows.push_back(mk(1, 0, 3'd7, 1, 0, expv(4, 0, 8'h80, 1, 0)));
    rows.push_back(mk(1, 1, 3'd6, 0, 0, expv(0, 2, 8'h80, 1, 0)));
    rows.push_back(mk(1, 0, 3'd6, 0, 0, expv(1, 7, 8'h80, 1, 0)));
    rows.push_back(mk(1, 0, 3'd6, 0, 0, expv(2, 5, 8'h80, 1, 0)));
    rows.push_back(mk(1, 0, 3'd6, 0, 0, expv(3, 0, 8'h40, 0, 0)));
    rows.push_back(mk(1, 0, 3'd6, 0, 0, expv(4, 0, 8'h40, 0, 0)));
    rows.push_back(mk(1, 0, 3'd6, 0, 0, expv(5, 0, 8'h40, 0, 0)));
    rows.push_back(mk(1, 0, 3'd6, 0, 0, expv(6, 3, 8'h40, 0, 0)));
    rows.push_back(mk(1, 1, 3'd6, 0, 0, expv(0, 2, 8'h40, 0, 0)));
    foreach (rows[k]) begin
      apply(rows[k], $sformatf("back_to_back_%0d", k));
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
      else n_pass++;
    end
  endtask

  task automatic test_interrupt();
    exp_t        e;
    logic [47:0] got;
    row_t        rows[$];
    bit          r;
    r = IRQ_ON;
    rows.push_back(mk(1, 0, 3'd0, 0, 0, expv(1, 7, 8'h40, 0, 0)));
    rows.push_back(mk(1, 0, 3'd0, 0, 0, expv(2, 5, 8'h40, 0, 0)));
    rows.push_back(mk(1, 0, 3'd0, 0, 0, expv(3, 0, 8'h01, 0, 0)));
    rows.push_back(mk(1, 0, 3'd0, 0, 0, expv(4, 7, 8'h01, 0, 0)));
    rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(5, 0, 8'h01, 0, r)));
    for (int s = 6; s < 16; s++) rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(s, 0, 8'h01, 0, r)));
    rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(0, 2, 8'h01, 0, r)));
    if (IRQ_ON) begin
      rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(1, 6, 8'h01, 0, 1)));
      rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(2, 0, 8'h01, 0, 1)));
      rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(0, 2, 8'h01, 0, 0)));
      rows.push_back(mk(1, 1, 3'd0, 0, 0, expv(0, 2, 8'h01, 0, 0)));
    end else begin
      rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(1, 7, 8'h01, 0, 0)));
      rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(2, 5, 8'h01, 0, 0)));
      rows.push_back(mk(1, 0, 3'd7, 0, 1, expv(3, 0, 8'h80, 0, 0)));
      rows.push_back(mk(1, 1, 3'd0, 0, 0, expv(0, 2, 8'h80, 0, 0)));
    end
    foreach (rows[k]) begin
      apply(rows[k], $sformatf("interrupt_%0d", k));
      e = sb.pop_front(); got = obs(); n_total++;
      if (got !== e.v) $display("FAIL %s: got %h required %h", e.tag, got, e.v);
      else n_pass++;
    end
  endtask

  initial begin
    bus.run    = 1'b0;
    bus.sc_clr = 1'b0;
    bus.ir_op  = 3'd0;
    bus.ir_i   = 1'b0;
    bus.ien    = 1'b0;
    bus.fgi    = 1'b0;
    bus.fgo    = 1'b0;
    test_reset();
    test_fetch_indirect();
    test_sta_clear();
    test_stall_wrap();
    test_back_to_back();
    test_interrupt();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/bus_sequencer.md
# bus_sequencer

Timing-and-control core for the basic computer. It generalises the combinational bus-select logic into a clocked block that owns the sequence counter (SC), the instruction decode register (D), the indirect bit (I) and the interrupt-cycle flip-flop (R). From that state it produces the encoded common-bus select S2..S0 every cycle. It sits between the instruction register and the common-bus multiplexer, and the datapath consumes its `t_state`, `d_dec` and `r_flag` outputs.

## Interface
- `SC_WIDTH`, 4: sequence counter width; T-state count is 2**SC_WIDTH; legal range 3..5.
- `SEL_WIDTH`, 3: bus select width; legal range 3 or more; upper bits read 0.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `run`  in  1  start/stop flip-flop S; 0 freezes all state.
- `sc_clr`  in  1  end-of-instruction clear from the datapath.
- `ir_op`  in  3  IR[14:12].
- `ir_i`  in  1  IR[15].
- `ien`, `fgi`, `fgo`  in  1 each  interrupt enable, input flag, output flag.
- `sc`  out  SC_WIDTH  sequence counter value.
- `t_state`  out  2**SC_WIDTH  one-hot decode of `sc`.
- `d_dec`  out  8  one-hot decode of the latched opcode.
- `i_flag`  out  1  latched indirect bit.
- `r_flag`  out  1  interrupt-cycle flip-flop.
- `bus_sel`  out  SEL_WIDTH  common-bus select: 0 none, 1 AR, 2 PC, 3 DR, 4 AC, 5 IR, 6 TR, 7 MEM.

## Operation
- Reset values: `sc`=0, `t_state`=1 (T0), opcode register=0 so `d_dec`=8'h01, `i_flag`=0, `r_flag`=0.
- SC update, in priority order:
  - `sc_clr`=1: SC becomes 0. This applies even when `run`=0.
  - `run`=0: SC holds.
  - Otherwise SC increments and wraps from 2**SC_WIDTH-1 to 0.
- Decode latch: on the edge ending T2 with R=0 and `run`=1, the opcode register loads `ir_op` and `i_flag` loads `ir_i`. They hold at all other times.
- `bus_sel` is a pure function of the registered state (Moore). Conditions per select value:
  - 1 AR: D4·T4 or D5·T5.
  - 2 PC: T0 or D5·T4.
  - 3 DR: D6·T6.
  - 4 AC: D3·T4.
  - 5 IR: R'·T2.
  - 6 TR: R·T1.
  - 7 MEM: R'·T1, or D7'·I·T3, or (D0|D1|D2)·T4.
  - If several conditions hold, the highest code wins. If none holds, the output is 0.
- Interrupt cycle (under the configuration macro):
  - R sets on an edge where `run`=1, SC is not 0, 1 or 2, `ien`=1, and `fgi` or `fgo` is 1.
  - While R=1, the latch does not load, and at R·T2 the block forces SC to 0 and clears R on the same edge.
  - `sc_clr` coinciding with R·T2 gives the same result.
  - A set condition arriving on the same edge as R·T2's clear is ignored (clear wins).

## Timing
- `bus_sel`, `t_state` and `d_dec` are valid from the same edge that updates SC, with zero added latency.
- D and I are first usable in T3 of each instruction.
- Reset is asynchronous on assertion. Deassertion is synchronous-safe: the first increment happens on the first edge after `rst_n` rises with `run`=1.
- Reset asserted mid-instruction returns all state to reset values immediately. No partial instruction resumes.

## Configuration
- `BUS_SEQ_INTERRUPT_EN` defined: R flip-flop, RT0/RT1/RT2 behaviour and the R'-qualified terms are all present as described.
- `BUS_SEQ_INTERRUPT_EN` undefined: R is the constant 0 and `r_flag`=0, so `ien`/`fgi`/`fgo` are unused. Bus select at T1 is always 7 and at T2 always 5.

## Test plan
- Reset: hold `rst_n`=0 with `run`=1 -> `sc`=0, `t_state`=1, `bus_sel`=2, `d_dec`=8'h01, `r_flag`=0; asserting reset mid-T4 gives the same values asynchronously.
- Fetch then indirect: `run`=1, `ir_op`=0, `ir_i`=1 -> `bus_sel` sequence T0..T4 = 2, 7, 5, 7, 7; `i_flag`=1 from T3.
- STA then clear: `ir_op`=3 -> `bus_sel`=4 at T4; pulse `sc_clr` at T4 -> next cycle `sc`=0; at T3 `bus_sel`=0 (D7=0, I=0).
- Stall and wrap: drop `run` at T5 for 3 cycles -> `sc` holds at 5; with no `sc_clr` and SC_WIDTH=4, `sc` wraps 15 -> 0.
- Interrupt: `ien`=1, `fgi`=1 rising at T4 -> `r_flag`=1 after that edge; next T0/T1/T2 show `bus_sel` 2, 6, 0; `r_flag` clears and `sc`=0 after T2.
- Macro off: same interrupt stimulus -> `r_flag` stays 0 and the normal fetch select sequence is unchanged.
